// File: rtl/reg_read_stage_if.sv
// rtl/reg_read_stage_if.sv - decode/regfile/writeback/execute bundle for the register read stage

interface reg_read_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [4:0]      in_rd;
  logic            in_rd_wr;
  logic [4:0]      rf_rd_reg_1;
  logic [4:0]      rf_rd_reg_2;
  logic [XLEN-1:0] rf_rd_data_1;
  logic [XLEN-1:0] rf_rd_data_2;
  logic            wb_wr_en;
  logic [4:0]      wb_wr_reg;
  logic [XLEN-1:0] wb_wr_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [4:0]      out_rd;
  logic            out_rd_wr;

  // Stage side: drives regfile addresses and the execute-facing entry.
  modport master (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wr,
    output in_ready,
    output rf_rd_reg_1, rf_rd_reg_2,
    input  rf_rd_data_1, rf_rd_data_2,
    input  wb_wr_en, wb_wr_reg, wb_wr_data,
    input  flush, out_ready,
    output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_wr
  );

  // Surrounding pipeline side: decode, register file, writeback, execute.
  modport slave (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_wr,
    input  in_ready,
    input  rf_rd_reg_1, rf_rd_reg_2,
    output rf_rd_data_1, rf_rd_data_2,
    output wb_wr_en, wb_wr_reg, wb_wr_data,
    output flush, out_ready,
    input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_wr
  );
endinterface

// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - operand read, writeback bypass, pending scoreboard and output register

module reg_read_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  reg_read_stage_if.master bus
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_wr_q, rd_wr_d;
  logic [NREG-1:0] pending_q, pending_d;

  logic            clr_rs1, clr_rs2, clr_rd;
  logic            hazard;
  logic            ready;
  logic            capture;
  logic [XLEN-1:0] res_rs1, res_rs2;

  // The register file returns the old value during a same-cycle write, so the
  // writeback data is forwarded; x0 always reads as zero.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_en,
    input logic [4:0]      wb_reg,
    input logic [XLEN-1:0] wb_data
  );
    if (rs == 5'd0) return '0;
    if (wb_en && (wb_reg == rs)) return wb_data;
    return rf_data;
  endfunction

  assign bus.rf_rd_reg_1 = bus.in_rs1;
  assign bus.rf_rd_reg_2 = bus.in_rs2;

  // Hazard detection: a pending register that writeback retires this cycle is no longer a hazard.
  always_comb begin
    clr_rs1 = bus.wb_wr_en && (bus.wb_wr_reg == bus.in_rs1) && (bus.in_rs1 != 5'd0);
    clr_rs2 = bus.wb_wr_en && (bus.wb_wr_reg == bus.in_rs2) && (bus.in_rs2 != 5'd0);
    clr_rd  = bus.wb_wr_en && (bus.wb_wr_reg == bus.in_rd)  && (bus.in_rd  != 5'd0);
    hazard  = ((bus.in_rs1 != 5'd0) && pending_q[bus.in_rs1] && !clr_rs1) ||
              ((bus.in_rs2 != 5'd0) && pending_q[bus.in_rs2] && !clr_rs2) ||
              (bus.in_rd_wr && (bus.in_rd != 5'd0) && pending_q[bus.in_rd] && !clr_rd);
    ready   = !rst_i && !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
    capture = bus.in_valid && ready;
    res_rs1 = resolve(bus.in_rs1, bus.rf_rd_data_1, bus.wb_wr_en, bus.wb_wr_reg, bus.wb_wr_data);
    res_rs2 = resolve(bus.in_rs2, bus.rf_rd_data_2, bus.wb_wr_en, bus.wb_wr_reg, bus.wb_wr_data);
  end

  // Next state of the output entry and scoreboard; clears are applied before sets.
  always_comb begin
    out_valid_d = out_valid_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rd_d        = rd_q;
    rd_wr_d     = rd_wr_q;
    pending_d   = pending_q;

    if (bus.wb_wr_en) pending_d[bus.wb_wr_reg] = 1'b0;

    if (bus.flush) begin
      out_valid_d = 1'b0;
      if (out_valid_q && rd_wr_q) pending_d[rd_q] = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      rs1_data_d  = res_rs1;
      rs2_data_d  = res_rs2;
      rd_d        = bus.in_rd;
      rd_wr_d     = bus.in_rd_wr;
      if (bus.in_rd_wr && (bus.in_rd != 5'd0)) pending_d[bus.in_rd] = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    pending_d[0] = 1'b0;
  end

  // State registers with synchronous reset discarding the entry and scoreboard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rd_q        <= 5'd0;
      rd_wr_q     <= 1'b0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rd_q        <= rd_d;
      rd_wr_q     <= rd_wr_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1_data = rs1_data_q;
  assign bus.out_rs2_data = rs2_data_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_rd_wr    = rd_wr_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - table vectors plus scoreboard bench for reg_read_stage

module tb_reg_read_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_read_stage_if #(.XLEN(32)) bus ();

  reg_read_stage #(.XLEN(32), .NREG(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] rf [32];
  assign bus.rf_rd_data_1 = rf[bus.rf_rd_reg_1];
  assign bus.rf_rd_data_2 = rf[bus.rf_rd_reg_2];

  typedef struct {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        rd_wr;
  } exp_t;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  exp_t q[$];
  exp_t cur_exp;
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rd_wr, input logic [31:0] e1, input logic [31:0] e2);
    bus.in_valid     = 1'b1;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_rd        = rd;
    bus.in_rd_wr     = rd_wr;
    cur_exp.rs1_data = e1;
    cur_exp.rs2_data = e2;
    cur_exp.rd       = rd;
    cur_exp.rd_wr    = rd_wr;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    bus.wb_wr_en   = en;
    bus.wb_wr_reg  = r;
    bus.wb_wr_data = d;
  endtask

  // Scoreboard: push on capture, pop and compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (bus.flush) begin
        if (bus.out_valid && q.size() > 0) e = q.pop_front();
      end else if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL sb_unexpected_out: got out_valid=1 expected no entry");
        end else begin
          e = q.pop_front();
          chk("sb_rs1_data", bus.out_rs1_data, e.rs1_data);
          chk("sb_rs2_data", bus.out_rs2_data, e.rs2_data);
          chk("sb_rd",       {27'd0, bus.out_rd}, {27'd0, e.rd});
          chk("sb_rd_wr",    {31'd0, bus.out_rd_wr}, {31'd0, e.rd_wr});
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(cur_exp);
    end
  end

  vec_t vecs [7];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hC000_0000 | i;
    rf[5] = 32'h0000_1234;

    vecs[0] = '{5'd5,  5'd0,  1'b0, 5'd0,  32'h0,         32'h0000_1234, 32'h0};
    vecs[1] = '{5'd3,  5'd4,  1'b0, 5'd0,  32'h0,         32'hC000_0003, 32'hC000_0004};
    vecs[2] = '{5'd3,  5'd4,  1'b1, 5'd4,  32'hAAAA_5555, 32'hC000_0003, 32'hAAAA_5555};
    vecs[3] = '{5'd6,  5'd6,  1'b1, 5'd6,  32'h1111_2222, 32'h1111_2222, 32'h1111_2222};
    vecs[4] = '{5'd0,  5'd0,  1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0,         32'h0};
    vecs[5] = '{5'd31, 5'd1,  1'b0, 5'd31, 32'h0000_0099, 32'hC000_001F, 32'hC000_0001};
    vecs[6] = '{5'd2,  5'd31, 1'b1, 5'd30, 32'h0000_0005, 32'hC000_0002, 32'hC000_001F};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_rd_wr = 1'b0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    cur_exp = '{32'h0, 32'h0, 5'd0, 1'b0};
    tick(); tick();

    // Reset state
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_rs1_data",  bus.out_rs1_data, 32'h0);
    chk("rst_rd",        {27'd0, bus.out_rd}, 32'd0);
    chk("rst_pending",   dut.pending_q, 32'h0);
    rst = 1'b0;

    // Table-driven operand resolution at full throughput
    for (int i = 0; i < 7; i++) begin
      wb(vecs[i].wb_en, vecs[i].wb_reg, vecs[i].wb_data);
      issue(vecs[i].rs1, vecs[i].rs2, 5'(i + 10), 1'b0, vecs[i].e1, vecs[i].e2);
      #1;
      chk("tbl_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("tbl_rf_addr1", {27'd0, bus.rf_rd_reg_1}, {27'd0, vecs[i].rs1});
      tick();
      chk("tbl_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.in_valid = 1'b0; wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("tbl_pending", dut.pending_q, 32'h0);

    // RAW hazard released by same-cycle writeback
    issue(5'd5, 5'd0, 5'd7, 1'b1, 32'h0000_1234, 32'h0);
    tick();
    chk("raw_out_rs1", bus.out_rs1_data, 32'h0000_1234);
    chk("raw_pend7_set", {31'd0, dut.pending_q[7]}, 32'd1);
    issue(5'd7, 5'd0, 5'd8, 1'b1, 32'hDEAD_BEEF, 32'h0);
    #1;
    chk("raw_stall", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("raw_drained", {31'd0, bus.out_valid}, 32'd0);
    wb(1'b1, 5'd7, 32'hDEAD_BEEF);
    #1;
    chk("raw_release", {31'd0, bus.in_ready}, 32'd1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    bus.in_valid = 1'b0;
    chk("raw_bypass", bus.out_rs1_data, 32'hDEAD_BEEF);
    chk("raw_pend7_clr", {31'd0, dut.pending_q[7]}, 32'd0);
    chk("raw_pend8_set", {31'd0, dut.pending_q[8]}, 32'd1);
    tick();
    wb(1'b1, 5'd8, 32'h0000_0008);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("raw_pend_empty", dut.pending_q, 32'h0);

    // Backpressure: entry held 3 cycles, writeback to its source must not alter it
    bus.out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd0, 1'b0, 32'hC000_0001, 32'hC000_0002);
    tick();
    issue(5'd3, 5'd4, 5'd0, 1'b0, 32'hC000_0003, 32'hC000_0004);
    wb(1'b1, 5'd1, 32'h0000_0077);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_rs1",   bus.out_rs1_data, 32'hC000_0001);
      chk("hold_rs2",   bus.out_rs2_data, 32'hC000_0002);
    end
    wb(1'b0, 5'd0, 32'h0);
    bus.out_ready = 1'b1;
    #1;
    chk("hold_release", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_rs1",   bus.out_rs1_data, 32'hC000_0003);
    tick();
    chk("b2b_drained", {31'd0, bus.out_valid}, 32'd0);

    // Flush of a held entry clears its pending bit and blocks capture
    bus.out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0);
    tick();
    chk("fl_pend9_set", {31'd0, dut.pending_q[9]}, 32'd1);
    issue(5'd2, 5'd0, 5'd0, 1'b0, 32'hC000_0002, 32'h0);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("fl_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_pend9_clr", {31'd0, dut.pending_q[9]}, 32'd0);
    tick();
    chk("fl_no_capture", {31'd0, bus.out_valid}, 32'd0);

    // Set wins over same-cycle clear; WAW stall
    issue(5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0);
    wb(1'b1, 5'd3, 32'h0000_3333);
    #1;
    chk("sc_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("sc_pend3", {31'd0, dut.pending_q[3]}, 32'd1);
    issue(5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0);
    #1;
    chk("waw_stall", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("waw_no_capture", {31'd0, bus.out_valid}, 32'd0);
    wb(1'b1, 5'd3, 32'h0000_3333);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("waw_pend_empty", dut.pending_q, 32'h0);

    // Reset mid-operation discards entry and scoreboard
    issue(5'd4, 5'd0, 5'd12, 1'b1, 32'hC000_0004, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_pending",   dut.pending_q, 32'h0);
    chk("mrst_out_rd",    {27'd0, bus.out_rd}, 32'd0);
    tick(); tick();
    chk("sb_queue_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Decode-side register-operand stage for the RISC-V core, acting as the initiator of the register file's read ports. It accepts one decoded instruction per cycle and drives the register file's read addresses. It returns operand data bypassed from the same-cycle writeback, tracks outstanding destination writes in a 32-bit pending scoreboard, and stalls on RAW/WAW hazards. Its output is a one-entry valid/ready pipeline register that feeds execute.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers (x0 hard-wired zero)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  5  source register indices
- in_rd  in  5  destination index
- in_rd_wr  in  1  instruction writes rd
- rf_rd_reg_1, rf_rd_reg_2  out  5  register file read addresses
- rf_rd_data_1, rf_rd_data_2  in  XLEN  register file read data (combinational read)
- wb_wr_en  in  1  writeback write enable (also wired to register file wr_en)
- wb_wr_reg  in  5  writeback index
- wb_wr_data  in  XLEN  writeback data
- flush  in  1  discard output entry
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- out_rs1_data, out_rs2_data  out  XLEN  resolved operands
- out_rd  out  5  registered in_rd
- out_rd_wr  out  1  registered in_rd_wr

## Operation
- rf_rd_reg_1 = in_rs1 and rf_rd_reg_2 = in_rs2, combinationally and unconditionally.
- Operand resolution, per source rsN:
  - rsN==0 → 0.
  - Else wb_wr_en && wb_wr_reg==rsN → wb_wr_data (bypass; the register file returns the old value during a same-cycle write).
  - Else rf_rd_data_N.
- Clear for register r: wb_wr_en && wb_wr_reg==r && r!=0.
- Hazard, any of:
  - rs1!=0 && pending[rs1] && !clear(rs1)
  - rs2!=0 && pending[rs2] && !clear(rs2)
  - in_rd_wr && rd!=0 && pending[rd] && !clear(rd)
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Capture (in_valid && in_ready):
  - Load out_* with resolved operands, in_rd, in_rd_wr.
  - out_valid←1.
  - If in_rd_wr && in_rd!=0, set pending[in_rd].
- Output drained without capture (out_valid && out_ready && !capture): out_valid←0.
- Scoreboard update order within a cycle: clear first, then set. A set and a clear of the same index in the same cycle leaves the bit at 1.
- pending[0] is always 0.
- Flush:
  - out_valid←0.
  - If out_valid && out_rd_wr, clear pending[out_rd].
  - No capture occurs in a flush cycle.
  - Flush beats out_ready.
- Held output: while out_valid && !out_ready, out_* are stable. Operands are not re-resolved, so a later writeback does not alter them.

## Timing
- Reset (synchronous, rst high at the clock edge):
  - out_valid=0, out_rs1_data=0, out_rs2_data=0, out_rd=0, out_rd_wr=0, pending=0.
  - in_ready=0 while rst is high.
- Reset mid-operation discards the output entry and the entire scoreboard.
- Latency: 1 cycle from capture to out_valid.
- Throughput: 1/cycle when there is no hazard and out_ready=1.
- A hazard that is cleared by writeback in cycle N allows capture in cycle N, with the bypassed value.
- A stalled instruction must hold its in_* inputs and in_valid until in_ready is 1.

## Test plan
- Reset, then issue rs1=5, rs2=0, rd=7, rd_wr=1 with RF x5=0x1234 → next cycle out_valid=1, out_rs1_data=0x1234, out_rs2_data=0, pending[7]=1.
- Issue rs1=7 while pending[7]=1 and no writeback → in_ready=0. Next cycle wb_wr_en=1, wb_wr_reg=7, wb_wr_data=0xDEADBEEF → captured that cycle, out_rs1_data=0xDEADBEEF, pending[7]=0.
- Issue rs1=0, rs2=0 with wb_wr_reg=0, wb_wr_data=0xFFFFFFFF, wb_wr_en=1 → both operands 0, pending unchanged.
- out_valid=1, out_ready=0 for 3 cycles while new instructions arrive → out_* stable and in_ready=0. Then out_ready=1 → back-to-back transfer with no bubble.
- Output entry rd=9, rd_wr=1 with out_ready=0, then flush=1 → out_valid=0, pending[9]=0, in_ready=0 in the flush cycle.
- Same cycle: capture rd=3, rd_wr=1 (pending[3] was 0) and wb_wr_reg=3 → pending[3]=1 afterward. Also check that WAW with pending[3]=1 and no writeback stalls.
